// File: rtl/dbus_uart_tx_if.sv
// CPU data-memory bus as seen by a memory-mapped responder.
// The responder drives read data and its address-decode hit back to the CPU side.
interface dbus_uart_tx_if;
    logic [29:0] DATA_ADDR;
    logic        DATA_WE;
    logic [3:0]  DATA_BE;
    logic [31:0] DATA_WD;
    logic [31:0] DATA_RD;
    logic        HIT;

    modport master (
        output DATA_ADDR, DATA_WE, DATA_BE, DATA_WD,
        input  DATA_RD, HIT
    );

    modport slave (
        input  DATA_ADDR, DATA_WE, DATA_BE, DATA_WD,
        output DATA_RD, HIT
    );
endinterface

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable bit period,
// status/control registers in a 4-word window on the data bus.
module dbus_uart_tx #(
    parameter logic [29:0] BASE_ADDR  = 30'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic           CLK,
    input  logic           RESET_N,
    dbus_uart_tx_if.slave  bus,
    output logic           TXD,
    output logic           IRQ
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] tick;
    logic [15:0] divisor;
    logic [15:0] period_m1;
    logic        en, irq_en, overrun;
    logic        wr, full, empty, busy;
    logic        push_req, push_ok, pop, clr, ovr_clr, ovr_set;
    logic        unused_wd;

    assign unused_wd = ^bus.DATA_WD[31:16];

    assign bus.HIT = (bus.DATA_ADDR[29:2] == BASE_ADDR[29:2]);
    assign wr      = bus.DATA_WE & bus.HIT;
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign IRQ     = irq_en & empty & ~busy;

    assign pop      = (state == IDLE) & en & ~empty;
    assign push_req = wr & (bus.DATA_ADDR[1:0] == 2'd0) & bus.DATA_BE[0];
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req & (~full | pop);
    assign ovr_set  = push_req & full & ~pop;
    assign clr      = wr & (bus.DATA_ADDR[1:0] == 2'd3) & bus.DATA_BE[0] & bus.DATA_WD[1];
    assign ovr_clr  = wr & (bus.DATA_ADDR[1:0] == 2'd3) & bus.DATA_BE[0] & bus.DATA_WD[2];
    assign period_m1 = (divisor == '0) ? '0 : divisor - 16'd1;

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= bus.DATA_WD[7:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok & ~pop)      count <= count + 1'b1;
            else if (pop & ~push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en      <= 1'b0;
            irq_en  <= 1'b0;
            overrun <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            if (wr && bus.DATA_ADDR[1:0] == 2'd2) begin
                if (bus.DATA_BE[0]) divisor[7:0]  <= bus.DATA_WD[7:0];
                if (bus.DATA_BE[1]) divisor[15:8] <= bus.DATA_WD[15:8];
            end
            if (wr && bus.DATA_ADDR[1:0] == 2'd3 && bus.DATA_BE[0]) begin
                en     <= bus.DATA_WD[0];
                irq_en <= bus.DATA_WD[3];
            end
        end
    end

    // tick counts down the remaining cycles of the current bit; the divisor
    // is re-sampled each time a new bit is entered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            TXD     <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            tick    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        TXD   <= 1'b0;
                        tick  <= period_m1;
                        state <= START;
                    end
                end
                START: begin
                    if (tick == '0) begin
                        TXD     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        tick    <= period_m1;
                        state   <= DATA;
                    end else begin
                        tick <= tick - 16'd1;
                    end
                end
                DATA: begin
                    if (tick == '0) begin
                        tick <= period_m1;
                        if (bit_cnt == 3'd7) begin
                            TXD   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TXD     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        tick <= tick - 16'd1;
                    end
                end
                STOP: begin
                    if (tick == '0) state <= IDLE;
                    else            tick  <= tick - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.DATA_RD = '0;
        if (bus.HIT) begin
            case (bus.DATA_ADDR[1:0])
                2'd1: begin
                    bus.DATA_RD[0]    = busy;
                    bus.DATA_RD[1]    = full;
                    bus.DATA_RD[2]    = empty;
                    bus.DATA_RD[3]    = overrun;
                    bus.DATA_RD[15:8] = 8'(count);
                end
                2'd2:    bus.DATA_RD[15:0] = divisor;
                2'd3: begin
                    bus.DATA_RD[0] = en;
                    bus.DATA_RD[3] = irq_en;
                end
                default: bus.DATA_RD = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed + randomized bench for dbus_uart_tx; a queue-based model predicts
// FIFO contents, status words and the expected serial bit stream.
module tb_dbus_uart_tx;
    localparam logic [29:0] BASE  = 30'h0000_1000;
    localparam int unsigned DEPTH = 8;

    logic CLK = 1'b0;
    logic RESET_N;
    logic TXD, IRQ;

    dbus_uart_tx_if bus_if();

    dbus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus_if), .TXD(TXD), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [7:0]  q[$];
    logic        ovr_m;
    logic        irq_en_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp(input logic busy);
        logic [31:0] s;
        s = '0;
        s[0] = busy;
        s[1] = (q.size() == DEPTH);
        s[2] = (q.size() == 0);
        s[3] = ovr_m;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    task automatic bus_write(input logic [29:0] addr, input logic [3:0] be, input logic [31:0] wd);
        @(negedge CLK);
        bus_if.DATA_ADDR = addr;
        bus_if.DATA_WE   = 1'b1;
        bus_if.DATA_BE   = be;
        bus_if.DATA_WD   = wd;
        @(posedge CLK);
        #1;
        bus_if.DATA_WE = 1'b0;
        bus_if.DATA_BE = '0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] off, input logic [31:0] exp);
        bus_if.DATA_ADDR = BASE + 30'(off);
        #1;
        check(tag, bus_if.DATA_RD, exp);
    endtask

    task automatic push(input logic [7:0] b);
        bus_write(BASE, 4'b0001, {24'h0, b});
        if (q.size() < DEPTH) q.push_back(b);
        else ovr_m = 1'b1;
    endtask

    // Next negedge must fall in the first cycle of the start bit.
    task automatic expect_frame(input int unsigned p);
        logic [7:0] b;
        logic       eb;
        b = q.pop_front();
        bus_if.DATA_ADDR = BASE + 30'd1;
        for (int i = 0; i < 10; i++) begin
            eb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int unsigned c = 0; c < p; c++) begin
                @(negedge CLK);
                check("txd_bit", 32'(TXD), 32'(eb));
                check("status_in_frame", bus_if.DATA_RD, status_exp(1'b1));
                check("irq_in_frame", 32'(IRQ), 32'(irq_en_m & 1'b0));
            end
        end
    endtask

    initial begin
        int unsigned div, p, n;
        RESET_N = 1'b0;
        bus_if.DATA_ADDR = BASE;
        bus_if.DATA_WE = 1'b0;
        bus_if.DATA_BE = '0;
        bus_if.DATA_WD = '0;
        ovr_m = 1'b0;
        irq_en_m = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        rd_check("reset_status", 2'd1, 32'h0000_0004);
        rd_check("reset_divisor", 2'd2, 32'h0000_01B2);
        rd_check("reset_control", 2'd3, 32'h0);
        check("reset_irq", 32'(IRQ), 32'h0);
        check("reset_txd", 32'(TXD), 32'h1);
        check("hit_base", 32'(bus_if.HIT), 32'h1);

        // single frame, P=4
        bus_write(BASE + 30'd2, 4'b0011, 32'd4);
        bus_write(BASE + 30'd3, 4'b0001, 32'h1);
        push(8'hA5);
        @(negedge CLK);
        check("idle_before_start", 32'(TXD), 32'h1);
        expect_frame(4);
        @(negedge CLK);
        rd_check("single_done_status", 2'd1, status_exp(1'b0));

        // back-to-back frames, P=2, IRQ after the second stop bit
        bus_write(BASE + 30'd3, 4'b0001, 32'h0);
        bus_write(BASE + 30'd2, 4'b0011, 32'd2);
        push(8'h00);
        push(8'hFF);
        bus_write(BASE + 30'd3, 4'b0001, 32'h9);
        irq_en_m = 1'b1;
        @(negedge CLK);
        check("b2b_idle0", 32'(TXD), 32'h1);
        expect_frame(2);
        @(negedge CLK);
        check("b2b_gap_txd", 32'(TXD), 32'h1);
        check("b2b_gap_irq", 32'(IRQ), 32'h0);
        expect_frame(2);
        @(negedge CLK);
        check("b2b_irq_after", 32'(IRQ), 32'h1);
        rd_check("b2b_status", 2'd1, status_exp(1'b0));

        // randomized bursts with random divisor (0 behaves as 1)
        bus_write(BASE + 30'd3, 4'b0001, 32'h0);
        irq_en_m = 1'b0;
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 5);
            p = (div == 0) ? 1 : div;
            n = $urandom_range(1, 4);
            bus_write(BASE + 30'd3, 4'b0001, 32'h0);
            bus_write(BASE + 30'd2, 4'b0011, div);
            for (int unsigned j = 0; j < n; j++) push(8'($urandom));
            bus_write(BASE + 30'd3, 4'b0001, 32'h1);
            @(negedge CLK);
            check("rnd_idle0", 32'(TXD), 32'h1);
            for (int unsigned j = 0; j < n; j++) begin
                expect_frame(p);
                @(negedge CLK);
                check("rnd_gap_txd", 32'(TXD), 32'h1);
            end
            rd_check("rnd_status", 2'd1, status_exp(1'b0));
        end

        // overflow, OVR_CLR, CLR
        bus_write(BASE + 30'd3, 4'b0001, 32'h0);
        for (int j = 0; j < 9; j++) push(8'($urandom));
        rd_check("ovf_status", 2'd1, status_exp(1'b0));
        check("ovf_status_const", bus_if.DATA_RD, 32'h0000_080A);
        bus_write(BASE + 30'd3, 4'b0001, 32'h4);
        ovr_m = 1'b0;
        rd_check("ovr_clr_status", 2'd1, 32'h0000_0802);
        bus_write(BASE + 30'd3, 4'b0001, 32'h2);
        q.delete();
        rd_check("clr_status", 2'd1, status_exp(1'b0));
        rd_check("clr_control", 2'd3, 32'h0);

        // byte enables and out-of-window writes
        bus_write(BASE + 30'd2, 4'b0011, 32'h0000_00FF);
        bus_write(BASE + 30'd2, 4'b0001, 32'h0000_1234);
        rd_check("be_divisor", 2'd2, 32'h0000_0034);
        bus_write(BASE + 30'd6, 4'b1111, 32'h0000_BEEF);
        bus_write(BASE + 30'd4, 4'b1111, 32'h0000_0077);
        bus_if.DATA_ADDR = BASE + 30'd6;
        #1;
        check("miss_hit", 32'(bus_if.HIT), 32'h0);
        check("miss_rd", bus_if.DATA_RD, 32'h0);
        rd_check("miss_divisor", 2'd2, 32'h0000_0034);
        rd_check("miss_status", 2'd1, 32'h0000_0004);

        // EN cleared mid-frame
        bus_write(BASE + 30'd2, 4'b0011, 32'd2);
        push(8'h3C);
        push(8'hC3);
        bus_write(BASE + 30'd3, 4'b0001, 32'h1);
        bus_write(BASE + 30'd3, 4'b0001, 32'h0);
        expect_frame(2);
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            check("en_off_txd", 32'(TXD), 32'h1);
        end
        rd_check("en_off_status", 2'd1, status_exp(1'b0));
        check("en_off_count", bus_if.DATA_RD, 32'h0000_0100);
        bus_write(BASE + 30'd3, 4'b0001, 32'h1);
        @(negedge CLK);
        check("en_on_idle", 32'(TXD), 32'h1);
        expect_frame(2);
        @(negedge CLK);
        rd_check("en_on_status", 2'd1, status_exp(1'b0));

        // asynchronous reset in the middle of a start bit
        bus_write(BASE + 30'd2, 4'b0011, 32'd20);
        push(8'h55);
        repeat (4) @(negedge CLK);
        check("pre_reset_txd", 32'(TXD), 32'h0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset_txd", 32'(TXD), 32'h1);
        check("async_reset_irq", 32'(IRQ), 32'h0);
        q.delete();
        ovr_m = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        rd_check("post_reset_status", 2'd1, status_exp(1'b0));
        rd_check("post_reset_divisor", 2'd2, 32'h0000_01B2);
        rd_check("post_reset_control", 2'd3, 32'h0);
        repeat (3) @(negedge CLK);
        check("post_reset_txd", 32'(TXD), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
